// File: rtl/snax_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among NumInp requesters.
// Winner indices are queued in an ID FIFO so in-order responses route back to their issuer.
module snax_tcdm_rr_arbiter #(
  parameter int unsigned NumInp         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumInp-1:0]                 inp_q_valid_i,
  output logic [NumInp-1:0]                 inp_q_ready_o,
  input  logic [NumInp*AddrWidth-1:0]       inp_q_addr_i,
  input  logic [NumInp-1:0]                 inp_q_write_i,
  input  logic [NumInp*DataWidth-1:0]       inp_q_data_i,
  input  logic [NumInp*(DataWidth/8)-1:0]   inp_q_strb_i,
  output logic [NumInp-1:0]                 inp_p_valid_o,
  output logic [DataWidth-1:0]              inp_p_data_o,
  output logic                              out_q_valid_o,
  input  logic                              out_q_ready_i,
  output logic [AddrWidth-1:0]              out_q_addr_o,
  output logic                              out_q_write_o,
  output logic [DataWidth-1:0]              out_q_data_o,
  output logic [(DataWidth/8)-1:0]          out_q_strb_o,
  input  logic                              out_p_valid_i,
  input  logic [DataWidth-1:0]              out_p_data_i,
  output logic                              err_o
);

  localparam int unsigned StrbWidth    = DataWidth / 8;
  localparam int unsigned IdxWidth     = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned FifoPtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth     = $clog2(MaxOutstanding + 1);

  logic [IdxWidth-1:0]     ptr_q, ptr_d;
  logic                    lock_q, lock_d;
  logic [IdxWidth-1:0]     lock_idx_q, lock_idx_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [FifoPtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [FifoPtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [IdxWidth-1:0]     id_q [MaxOutstanding];
  logic [IdxWidth-1:0]     id_d [MaxOutstanding];
  logic                    err_q, err_d;

  logic [IdxWidth-1:0]     arb_idx;
  logic                    arb_found;
  int unsigned             cand;
  logic [IdxWidth-1:0]     cand_idx;
  logic [IdxWidth-1:0]     gnt_idx;
  logic [IdxWidth-1:0]     head_idx;
  logic                    not_full;
  logic                    push;
  logic                    pop;

  function automatic logic [FifoPtrWidth-1:0] wrap_inc(input logic [FifoPtrWidth-1:0] p);
    return (p == FifoPtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // First valid requester scanning upward from ptr, wrapping at NumInp.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      cand     = (32'(ptr_q) + i) % NumInp;
      cand_idx = IdxWidth'(cand);
      if (!arb_found && inp_q_valid_i[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign gnt_idx  = lock_q ? lock_idx_q : arb_idx;
  assign not_full = (cnt_q < CntWidth'(MaxOutstanding));

  assign out_q_valid_o = ((|inp_q_valid_i) | lock_q) & not_full;
  assign push          = out_q_valid_o & out_q_ready_i;
  assign pop           = out_p_valid_i & (cnt_q != '0);
  assign head_idx      = id_q[rd_ptr_q];

  always_comb begin
    out_q_addr_o  = inp_q_addr_i[gnt_idx*AddrWidth +: AddrWidth];
    out_q_write_o = inp_q_write_i[gnt_idx];
    out_q_data_o  = inp_q_data_i[gnt_idx*DataWidth +: DataWidth];
    out_q_strb_o  = inp_q_strb_i[gnt_idx*StrbWidth +: StrbWidth];
  end

  always_comb begin
    inp_q_ready_o = '0;
    if (push) inp_q_ready_o[gnt_idx] = 1'b1;
  end

  // Response routing depends only on the registered FIFO head, never on the request side.
  always_comb begin
    inp_p_valid_o = '0;
    if (pop) inp_p_valid_o[head_idx] = 1'b1;
  end

  assign inp_p_data_o = out_p_data_i;
  assign err_o        = err_q;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      ptr_d  = (gnt_idx == IdxWidth'(NumInp - 1)) ? '0 : gnt_idx + 1'b1;
      lock_d = 1'b0;
    end else if (out_q_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  always_comb begin
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      id_d[wr_ptr_q] = gnt_idx;
      wr_ptr_d       = wrap_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = wrap_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q | (out_p_valid_i & (cnt_q == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) id_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      id_q       <= id_d;
    end
  end

endmodule

// File: tb/tb_snax_tcdm_rr_arbiter.sv
// Scoreboard bench for snax_tcdm_rr_arbiter: queue-based reference model for grants,
// an emulated in-order TCDM, and a decoupled response monitor.
module tb_snax_tcdm_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      inp_q_valid_i;
  logic [N-1:0]      inp_q_ready_o;
  logic [N*AW-1:0]   inp_q_addr_i;
  logic [N-1:0]      inp_q_write_i;
  logic [N*DW-1:0]   inp_q_data_i;
  logic [N*SW-1:0]   inp_q_strb_i;
  logic [N-1:0]      inp_p_valid_o;
  logic [DW-1:0]     inp_p_data_o;
  logic              out_q_valid_o;
  logic              out_q_ready_i;
  logic [AW-1:0]     out_q_addr_o;
  logic              out_q_write_o;
  logic [DW-1:0]     out_q_data_o;
  logic [SW-1:0]     out_q_strb_o;
  logic              out_p_valid_i;
  logic [DW-1:0]     out_p_data_i;
  logic              err_o;

  always #5 clk = ~clk;

  snax_tcdm_rr_arbiter #(
    .NumInp(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inp_q_valid_i(inp_q_valid_i), .inp_q_ready_o(inp_q_ready_o),
    .inp_q_addr_i(inp_q_addr_i), .inp_q_write_i(inp_q_write_i),
    .inp_q_data_i(inp_q_data_i), .inp_q_strb_i(inp_q_strb_i),
    .inp_p_valid_o(inp_p_valid_o), .inp_p_data_o(inp_p_data_o),
    .out_q_valid_o(out_q_valid_o), .out_q_ready_i(out_q_ready_i),
    .out_q_addr_o(out_q_addr_o), .out_q_write_o(out_q_write_o),
    .out_q_data_o(out_q_data_o), .out_q_strb_o(out_q_strb_o),
    .out_p_valid_i(out_p_valid_i), .out_p_data_i(out_p_data_i),
    .err_o(err_o)
  );

  // Requester state: a request stays pending (valid, stable payload) until accepted.
  logic [N-1:0]  pend;
  logic [N-1:0]  acc_mask;
  logic [AW-1:0] r_addr  [N];
  logic          r_write [N];
  logic [DW-1:0] r_data  [N];
  logic [SW-1:0] r_strb  [N];
  bit            force_read;

  always_comb begin
    inp_q_valid_i = pend;
    inp_q_addr_i  = '0;
    inp_q_write_i = '0;
    inp_q_data_i  = '0;
    inp_q_strb_i  = '0;
    for (int i = 0; i < N; i++) begin
      inp_q_addr_i[i*AW +: AW] = r_addr[i];
      inp_q_write_i[i]         = r_write[i];
      inp_q_data_i[i*DW +: DW] = r_data[i];
      inp_q_strb_i[i*SW +: SW] = r_strb[i];
    end
  end

  typedef struct { logic [DW-1:0] data; int due; } tcdm_t;
  typedef struct { int id; logic [DW-1:0] data; } exp_t;

  int            m_ptr;
  bit            m_lock;
  int            m_lock_idx;
  int            m_ids[$];
  bit            m_err;
  tcdm_t         tcdm_q[$];
  exp_t          sb_q[$];
  logic [DW-1:0] fixed_q[$];
  int            lat_min = 1;
  int            lat_max = 1;
  int            cyc = 0;
  int            gcount[N];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_lock = 1'b0;
    m_lock_idx = 0;
    m_err = 1'b0;
    m_ids.delete();
    tcdm_q.delete();
    sb_q.delete();
  endtask

  task automatic do_cycle(input logic [N-1:0] new_mask, input bit rdy,
                          input bit allow_resp, input bit spurious);
    int g;
    bit found;
    bit ev;
    logic [N-1:0] er;
    logic [DW-1:0] d;
    tcdm_t t;
    exp_t e;
    @(negedge clk);
    cyc++;
    pend = pend & ~acc_mask;
    acc_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && new_mask[i]) begin
        pend[i]    = 1'b1;
        r_addr[i]  = $urandom;
        r_write[i] = force_read ? 1'b0 : 1'($urandom_range(0, 1));
        r_data[i]  = $urandom;
        r_strb[i]  = SW'($urandom);
      end
    end
    out_q_ready_i = rdy;
    out_p_valid_i = 1'b0;
    out_p_data_i  = $urandom;
    if (spurious) begin
      out_p_valid_i = 1'b1;
    end else if (allow_resp && tcdm_q.size() > 0 && tcdm_q[0].due <= cyc) begin
      out_p_valid_i = 1'b1;
      out_p_data_i  = tcdm_q[0].data;
      void'(tcdm_q.pop_front());
    end
    #1;
    ev = ((pend != '0) || m_lock) && (m_ids.size() < MO);
    g = 0;
    if (m_lock) begin
      g = m_lock_idx;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && pend[(m_ptr + k) % N]) begin
          found = 1'b1;
          g = (m_ptr + k) % N;
        end
      end
    end
    er = (ev && rdy) ? (N'(1) << g) : '0;
    check("out_q_valid", 64'(out_q_valid_o), 64'(ev));
    check("inp_q_ready", 64'(inp_q_ready_o), 64'(er));
    check("err_o", 64'(err_o), 64'(m_err));
    if (ev) begin
      check("out_q_addr", 64'(out_q_addr_o), 64'(r_addr[g]));
      check("out_q_write", 64'(out_q_write_o), 64'(r_write[g]));
      check("out_q_data", 64'(out_q_data_o), 64'(r_data[g]));
      check("out_q_strb", 64'(out_q_strb_o), 64'(r_strb[g]));
    end
    for (int i = 0; i < N; i++) gcount[i] += int'(inp_q_ready_o[i]);
    if (out_p_valid_i) begin
      if (m_ids.size() == 0) m_err = 1'b1;
      else void'(m_ids.pop_front());
    end
    if (ev && rdy) begin
      d = (fixed_q.size() > 0) ? fixed_q.pop_front() : DW'($urandom);
      t.data = d;
      t.due  = cyc + $urandom_range(lat_min, lat_max);
      tcdm_q.push_back(t);
      e.id = g;
      e.data = d;
      sb_q.push_back(e);
      m_ids.push_back(g);
      m_ptr = (g + 1) % N;
      m_lock = 1'b0;
      acc_mask[g] = 1'b1;
    end else if (ev) begin
      m_lock = 1'b1;
      m_lock_idx = g;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((tcdm_q.size() > 0 || (pend & ~acc_mask) != '0) && n < 200) begin
      do_cycle('0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    do_cycle('0, 1'b0, 1'b0, 1'b0);
    check("drain_tcdm_empty", 64'(tcdm_q.size()), 64'd0);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    pend = '0;
    acc_mask = '0;
    out_q_ready_i = 1'b0;
    out_p_valid_i = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_q_valid", 64'(out_q_valid_o), 64'd0);
    check("rst_q_ready", 64'(inp_q_ready_o), 64'd0);
    check("rst_p_valid", 64'(inp_p_valid_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every response the DUT presents must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inp_p_valid_o != '0) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 64'(inp_p_valid_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_route", 64'(inp_p_valid_o), 64'(1) << e.id);
          check("resp_data", 64'(inp_p_data_o), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pend = '0;
    acc_mask = '0;
    force_read = 1'b0;
    out_q_ready_i = 1'b0;
    out_p_valid_i = 1'b0;
    out_p_data_i = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_write[i] = 1'b0; r_data[i] = '0; r_strb[i] = '0; gcount[i] = 0;
    end
    model_reset();
    #1;
    check("reset_q_valid", 64'(out_q_valid_o), 64'd0);
    check("reset_q_ready", 64'(inp_q_ready_o), 64'd0);
    check("reset_p_valid", 64'(inp_p_valid_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fairness: both requesters valid every cycle, responses at latency 1.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    repeat (8) do_cycle(2'b11, 1'b1, 1'b1, 1'b0);
    check("fair_grants_0", 64'(gcount[0]), 64'd4);
    check("fair_grants_1", 64'(gcount[1]), 64'd4);
    drain();

    // Lock: requester 1 stalled, requester 0 joins while stalled.
    do_cycle(2'b10, 1'b0, 1'b0, 1'b0);
    do_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b0);
    do_cycle(2'b00, 1'b1, 1'b0, 1'b0);
    do_cycle(2'b00, 1'b1, 1'b0, 1'b0);
    drain();

    // Full: four outstanding, fifth blocked even while a response pops.
    lat_min = 1; lat_max = 1;
    repeat (4) do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b1, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    drain();

    // Routing with fixed data and latency 3.
    lat_min = 3; lat_max = 3;
    force_read = 1'b1;
    fixed_q.push_back(32'hA5A5_0000);
    fixed_q.push_back(32'h0000_5A5A);
    do_cycle(2'b01, 1'b1, 1'b1, 1'b0);
    do_cycle(2'b10, 1'b1, 1'b1, 1'b0);
    repeat (4) do_cycle(2'b00, 1'b0, 1'b1, 1'b0);
    force_read = 1'b0;
    drain();

    // Push and pop in the same cycle at cnt=3.
    lat_min = 1; lat_max = 1;
    repeat (3) do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b1, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    drain();

    // Spurious response with nothing outstanding.
    do_cycle(2'b00, 1'b0, 1'b0, 1'b1);
    do_cycle(2'b00, 1'b0, 1'b0, 1'b0);

    // Reset with two outstanding and ptr=1.
    lat_min = 5; lat_max = 5;
    do_cycle(2'b10, 1'b1, 1'b0, 1'b0);
    do_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    do_reset_mid();
    lat_min = 1; lat_max = 2;
    do_cycle(2'b00, 1'b0, 1'b0, 1'b1);
    do_cycle(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // Randomized traffic.
    lat_min = 1; lat_max = 6;
    for (int c = 0; c < 3000; c++) begin
      do_cycle(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
